data_former_burst: RTL and testbench

//  Parametrised successor to the single-word SPI data former. Generates bursts of
//  1..P_BURST_MAX words from a selectable pattern generator (counter/LFSR/walking-one/

---
 rtl/data_former_burst.sv | 177 +++++++++++++++++
 tb/tb_data_former_burst.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_former_burst.sv
// Burst pattern generator (counter / LFSR / walking-one / constant) on a valid/ready stream.
// Optional parity output on the data word when DATA_FORMER_PARITY_EN is defined.
module data_former_burst #(
    parameter int unsigned                 P_DATA_WIDTH = 8,
    parameter int unsigned                 P_BURST_MAX  = 16,
    parameter logic [P_DATA_WIDTH-1:0]     P_LFSR_TAPS  = P_DATA_WIDTH'(8'hB8),
    localparam int unsigned                BL_W         = $clog2(P_BURST_MAX + 1)
) (
    input  logic                    clk_100,
    input  logic                    a_rst_n,
    input  logic                    s_rst,
    input  logic [1:0]              mode,
    input  logic [P_DATA_WIDTH-1:0] seed,
    input  logic                    seed_load,
    input  logic                    next_count,
    input  logic [BL_W-1:0]         burst_len,
    input  logic                    start_send,
    input  logic                    ready,
    output logic                    valid,
    output logic [P_DATA_WIDTH-1:0] data,
    output logic                    last,
    output logic                    busy,
`ifdef DATA_FORMER_PARITY_EN
    output logic                    parity,
`endif
    output logic                    done
);

    localparam int unsigned DW = P_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   gen_q, gen_d;
    logic [DW-1:0]   data_q, data_d;
    logic [BL_W-1:0] rem_q, rem_d;
    logic [1:0]      mode_q, mode_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef DATA_FORMER_PARITY_EN
    logic            parity_q, parity_d;
`endif

    // Advance the pattern generator by one word; zero is an escape state for LFSR/walking-one.
    function automatic logic [DW-1:0] step_f(input logic [DW-1:0] g, input logic [1:0] m);
        logic [DW-1:0] r;
        unique case (m)
            2'd0:    r = g + DW'(1);
            2'd1:    r = (g == '0) ? DW'(1) : ((g >> 1) ^ (g[0] ? P_LFSR_TAPS : '0));
            2'd2:    r = (g == '0) ? DW'(1) : {g[DW-2:0], g[DW-1]};
            default: r = g;
        endcase
        return r;
    endfunction

    logic          len_ok_c;
    logic [DW-1:0] gen_step_c;

    assign len_ok_c   = (burst_len != '0) && (burst_len <= BL_W'(P_BURST_MAX));
    assign gen_step_c = step_f(gen_q, (state_q == S_IDLE) ? mode : mode_q);

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    gen_d = seed;
                end else if (start_send && len_ok_c) begin
                    mode_d  = mode;
                    rem_d   = burst_len;
                    data_d  = gen_q;
                    valid_d = 1'b1;
                    last_d  = (burst_len == BL_W'(1));
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                end else if (next_count) begin
                    gen_d = gen_step_c;
                end
            end
            S_SEND: begin
                // Next word is presented the cycle after a handshake, so there is no bubble.
                if (ready) begin
                    gen_d = gen_step_c;
                    if (rem_q == BL_W'(1)) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        data_d = gen_step_c;
                        rem_d  = rem_q - BL_W'(1);
                        last_d = (rem_q == BL_W'(2));
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (s_rst) begin
            state_d = S_IDLE;
            gen_d   = '0;
            data_d  = '0;
            rem_d   = '0;
            mode_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

`ifdef DATA_FORMER_PARITY_EN
    assign parity_d = ^data_d;
`endif

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q  <= S_IDLE;
            gen_q    <= '0;
            data_q   <= '0;
            rem_q    <= '0;
            mode_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DATA_FORMER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gen_q    <= gen_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DATA_FORMER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign valid  = valid_q;
    assign data   = data_q;
    assign last   = last_q;
    assign busy   = busy_q;
    assign done   = done_q;
`ifdef DATA_FORMER_PARITY_EN
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_data_former_burst.sv
// Directed bench for data_former_burst; parity checks are enabled with DATA_FORMER_PARITY_EN.
module tb_data_former_burst;

    localparam int unsigned DW   = 8;
    localparam int unsigned BL_W = 5;

    logic            clk_100 = 1'b0;
    logic            a_rst_n;
    logic            s_rst;
    logic [1:0]      mode;
    logic [DW-1:0]   seed;
    logic            seed_load;
    logic            next_count;
    logic [BL_W-1:0] burst_len;
    logic            start_send;
    logic            ready;
    logic            valid;
    logic [DW-1:0]   data;
    logic            last;
    logic            busy;
    logic            done;
`ifdef DATA_FORMER_PARITY_EN
    logic            parity;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int hs    = 0;

    data_former_burst #(
        .P_DATA_WIDTH(DW),
        .P_BURST_MAX (16),
        .P_LFSR_TAPS (8'hB8)
    ) dut (
        .clk_100   (clk_100),
        .a_rst_n   (a_rst_n),
        .s_rst     (s_rst),
        .mode      (mode),
        .seed      (seed),
        .seed_load (seed_load),
        .next_count(next_count),
        .burst_len (burst_len),
        .start_send(start_send),
        .ready     (ready),
        .valid     (valid),
        .data      (data),
        .last      (last),
        .busy      (busy),
`ifdef DATA_FORMER_PARITY_EN
        .parity    (parity),
`endif
        .done      (done)
    );

    always #5 clk_100 = ~clk_100;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [DW-1:0] d, input logic l);
        check({tag, ".valid"}, 32'(valid), 32'd1);
        check({tag, ".data"},  32'(data),  32'(d));
        check({tag, ".last"},  32'(last),  32'(l));
        check({tag, ".busy"},  32'(busy),  32'd1);
`ifdef DATA_FORMER_PARITY_EN
        check({tag, ".parity"}, 32'(parity), 32'(^d));
`endif
    endtask

    task automatic expect_done(input string tag);
        tick();
        check({tag, ".done"},  32'(done),  32'd1);
        check({tag, ".dbusy"}, 32'(busy),  32'd1);
        check({tag, ".dval"},  32'(valid), 32'd0);
        check({tag, ".dlast"}, 32'(last),  32'd0);
        tick();
        check({tag, ".done0"}, 32'(done),  32'd0);
        check({tag, ".busy0"}, 32'(busy),  32'd0);
    endtask

    task automatic load(input logic [1:0] m, input logic [DW-1:0] s);
        mode      = m;
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic start(input logic [BL_W-1:0] n);
        burst_len  = n;
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
    endtask

    initial begin
        a_rst_n    = 1'b0;
        s_rst      = 1'b0;
        mode       = 2'd0;
        seed       = '0;
        seed_load  = 1'b0;
        next_count = 1'b0;
        burst_len  = '0;
        start_send = 1'b0;
        ready      = 1'b0;
        tick();
        tick();
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.data",  32'(data),  32'd0);
        check("rst.last",  32'(last),  32'd0);
        check("rst.busy",  32'(busy),  32'd0);
        check("rst.done",  32'(done),  32'd0);
        a_rst_n = 1'b1;
        tick();

        // Counter burst of 4 from seed 05
        ready = 1'b1;
        load(2'd0, 8'h05);
        start(5'd4);
        expect_word("t1w0", 8'h05, 1'b0); tick();
        expect_word("t1w1", 8'h06, 1'b0); tick();
        expect_word("t1w2", 8'h07, 1'b0); tick();
        expect_word("t1w3", 8'h08, 1'b1);
        expect_done("t1");

        // LFSR burst of 4 then a single-word burst continuing the sequence
        load(2'd1, 8'h01);
        start(5'd4);
        expect_word("t2w0", 8'h01, 1'b0); tick();
        expect_word("t2w1", 8'hB8, 1'b0); tick();
        expect_word("t2w2", 8'h5C, 1'b0); tick();
        expect_word("t2w3", 8'h2E, 1'b1);
        expect_done("t2");
        start(5'd1);
        expect_word("t2b", 8'h17, 1'b1);
        expect_done("t2b");

        // Backpressure with counter wrap
        load(2'd0, 8'hFE);
        start(5'd3);
        hs = 0;
        ready = 1'b1; expect_word("t3c0", 8'hFE, 1'b0); if (valid && ready) hs++; tick();
        ready = 1'b0; expect_word("t3c1", 8'hFF, 1'b0); if (valid && ready) hs++; tick();
        ready = 1'b0; expect_word("t3c2", 8'hFF, 1'b0); if (valid && ready) hs++; tick();
        ready = 1'b1; expect_word("t3c3", 8'hFF, 1'b0); if (valid && ready) hs++; tick();
        ready = 1'b1; expect_word("t3c4", 8'h00, 1'b1); if (valid && ready) hs++;
        expect_done("t3");
        check("t3.handshakes", 32'(hs), 32'd3);

        // Zero and oversize lengths are ignored; next_count steps in IDLE
        start(5'd0);
        check("t4.len0.valid", 32'(valid), 32'd0);
        check("t4.len0.busy",  32'(busy),  32'd0);
        tick();
        check("t4.len0.busy2", 32'(busy),  32'd0);
        s_rst = 1'b1; tick(); s_rst = 1'b0;
        mode = 2'd0;
        next_count = 1'b1; tick(); tick(); tick(); next_count = 1'b0;
        start(5'd17);
        check("t4.len17.valid", 32'(valid), 32'd0);
        check("t4.len17.busy",  32'(busy),  32'd0);
        start(5'd1);
        expect_word("t4w", 8'h03, 1'b1);
        expect_done("t4");

        // Walking-one wraps; mode changes during SEND are ignored
        load(2'd2, 8'h80);
        start(5'd2);
        mode = 2'd0;
        expect_word("t7w0", 8'h80, 1'b0); tick();
        expect_word("t7w1", 8'h01, 1'b1);
        expect_done("t7");

        // Constant mode
        load(2'd3, 8'h5A);
        start(5'd2);
        expect_word("t8w0", 8'h5A, 1'b0); tick();
        expect_word("t8w1", 8'h5A, 1'b1);
        expect_done("t8");

        // Async reset mid-burst aborts immediately
        load(2'd0, 8'h10);
        start(5'd5);
        expect_word("t5w0", 8'h10, 1'b0); tick();
        expect_word("t5w1", 8'h11, 1'b0); tick();
        expect_word("t5w2", 8'h12, 1'b0);
        #2 a_rst_n = 1'b0;
        #1;
        check("t5.arst.valid", 32'(valid), 32'd0);
        check("t5.arst.busy",  32'(busy),  32'd0);
        check("t5.arst.last",  32'(last),  32'd0);
        check("t5.arst.done",  32'(done),  32'd0);
        tick();
        check("t5.arst.done2", 32'(done),  32'd0);
        a_rst_n = 1'b1;
        tick();
        check("t5.arst.done3", 32'(done),  32'd0);
        mode = 2'd0;
        start(5'd1);
        expect_word("t5.gen0", 8'h00, 1'b1);
        expect_done("t5g");

        // Sync clear mid-burst takes effect at the next edge
        load(2'd0, 8'h20);
        start(5'd5);
        expect_word("t5sw0", 8'h20, 1'b0); tick();
        expect_word("t5sw1", 8'h21, 1'b0); tick();
        s_rst = 1'b1;
        #1;
        check("t5.srst.pre", 32'(valid), 32'd1);
        tick();
        s_rst = 1'b0;
        check("t5.srst.valid", 32'(valid), 32'd0);
        check("t5.srst.busy",  32'(busy),  32'd0);
        check("t5.srst.last",  32'(last),  32'd0);
        tick();
        check("t5.srst.done",  32'(done),  32'd0);
        start(5'd1);
        expect_word("t5s.gen0", 8'h00, 1'b1);
        expect_done("t5s");

        // Counter 01,02,03 exercises parity 1,1,0 when enabled
        load(2'd0, 8'h01);
        start(5'd3);
        expect_word("t6w0", 8'h01, 1'b0); tick();
        expect_word("t6w1", 8'h02, 1'b0); tick();
        expect_word("t6w2", 8'h03, 1'b1);
`ifdef DATA_FORMER_PARITY_EN
        check("t6.parity3", 32'(parity), 32'd0);
`endif
        expect_done("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
